rx_dc_offset_canceller: RTL and testbench

//  Removes DC offset from the I/Q ADC samples before they enter the Rx demodulator (mixer/NCO/Gardner path).

---
 rtl/rx_dc_offset_canceller.sv | 192 +++++++++++++++++++
 tb/tb_rx_dc_offset_canceller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dc_offset_canceller.sv
// rx_dc_offset_canceller
// Removes the DC offset from signed I/Q ADC samples before the Rx demodulator.
// The block estimates the mean of each channel over fixed windows of
// 2^WIN_LOG2 accepted samples and subtracts the latest estimate from every
// sample, saturating the result to the sample range.
//
// Sample flow:
//   - Correction always runs, even while frozen or clearing.
//   - Latency is one clock.
//   - The estimate only moves at a window end.

module rx_dc_offset_canceller #(
  parameter int WIDTH    = 12,
  parameter int WIN_LOG2 = 8
) (
  input  logic                    clk_32M768,
  input  logic                    rst_n_32M768,
  input  logic signed [WIDTH-1:0] ADC_I,
  input  logic signed [WIDTH-1:0] ADC_Q,
  input  logic                    in_valid,
  input  logic                    freeze,
  input  logic                    clear,
  output logic signed [WIDTH-1:0] I_out,
  output logic signed [WIDTH-1:0] Q_out,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] offset_I,
  output logic signed [WIDTH-1:0] offset_Q,
  output logic                    locked
);

  // Accumulator width sizing:
  //   - A full window of 2^WIN_LOG2 samples, plus the half-LSB rounding term,
  //     always fits in WIDTH+WIN_LOG2 signed bits.
  //   - So no guard bit is needed.
  localparam int ACC_W = WIDTH + WIN_LOG2;

  localparam logic [WIN_LOG2-1:0]     CNT_LAST   = '1;
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (WIN_LOG2 - 1));
  localparam logic signed [WIDTH-1:0] SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAMPLE_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [WIN_LOG2-1:0]     cnt;

  logic                    accept;
  logic                    window_end;
  logic signed [ACC_W-1:0] acc_total_i;
  logic signed [ACC_W-1:0] acc_total_q;
  logic signed [ACC_W-1:0] rounded_i;
  logic signed [ACC_W-1:0] rounded_q;
  logic signed [WIDTH-1:0] est_i;
  logic signed [WIDTH-1:0] est_q;
  logic signed [WIDTH-1:0] corr_i;
  logic signed [WIDTH-1:0] corr_q;

  // Saturating subtraction.
  //   - Computed one bit wider so the true difference is always representable.
  //   - It is then clamped back into WIDTH bits.
  function automatic logic signed [WIDTH-1:0] sat_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] diff;
    diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat_sub = diff[WIDTH] ? SAMPLE_MIN : SAMPLE_MAX;
    end else begin
      sat_sub = diff[WIDTH-1:0];
    end
  endfunction

  // Decode which samples feed the estimator.
  //   - A clear or freeze in the same cycle keeps the sample out of the
  //     window.
  //   - The sample is still corrected and output.
  always_comb begin
    accept     = in_valid & ~freeze & ~clear;
    window_end = (cnt == CNT_LAST);
  end

  // Window arithmetic and rounding.
  //   - Running sums include the current sample.
  //   - Rounding adds half an LSB of the final mean, then takes the upper
  //     WIDTH bits.
  //   - Taking the upper bits is a floor divide by 2^WIN_LOG2, giving round
  //     half up overall.
  always_comb begin
    acc_total_i = acc_i + {{WIN_LOG2{ADC_I[WIDTH-1]}}, ADC_I};
    acc_total_q = acc_q + {{WIN_LOG2{ADC_Q[WIDTH-1]}}, ADC_Q};
    rounded_i   = acc_total_i + ROUND_HALF;
    rounded_q   = acc_total_q + ROUND_HALF;
    est_i       = rounded_i[ACC_W-1:WIN_LOG2];
    est_q       = rounded_q[ACC_W-1:WIN_LOG2];
  end

  // Correction uses the offset registers as they stand before the edge.
  //   - So a window-end sample is still corrected with the old estimate.
  always_comb begin
    corr_i = sat_sub(ADC_I, offset_I);
    corr_q = sat_sub(ADC_Q, offset_Q);
  end

  // Lock state register.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state <= ACQUIRE;
    end else begin
      state <= state_next;
    end
  end

  // Lock state transitions.
  //   - clear always returns to ACQUIRE.
  //   - The first completed window moves to TRACK.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACQUIRE;
    end else if (accept && window_end) begin
      state_next = TRACK;
    end
  end

  assign locked = (state == TRACK);

  // Corrected output stage.
  //   - out_valid mirrors in_valid one cycle later.
  //   - Outputs hold between samples.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      out_valid <= 1'b0;
      I_out     <= '0;
      Q_out     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        I_out <= corr_i;
        Q_out <= corr_q;
      end
    end
  end

  // Window accumulators and sample counter.
  //   - These restart on clear and at every window end.
  //   - While frozen, the partial window is parked and resumes later.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (clear) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (window_end) begin
        acc_i <= '0;
        acc_q <= '0;
      end else begin
        acc_i <= acc_total_i;
        acc_q <= acc_total_q;
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Offset estimate registers.
  //   - Loaded only when a window completes.
  //   - Zeroed by clear.
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      offset_I <= '0;
      offset_Q <= '0;
    end else if (clear) begin
      offset_I <= '0;
      offset_Q <= '0;
    end else if (accept && window_end) begin
      offset_I <= est_i;
      offset_Q <= est_q;
    end
  end

endmodule

// File: tb/tb_rx_dc_offset_canceller.sv
// tb_rx_dc_offset_canceller
// Directed tests for the DC offset canceller.
//   - WIDTH=12, WIN_LOG2=8.
//   - Samples are presented every second clock.
//   - All expected values are worked out by hand from the window contents.

module tb_rx_dc_offset_canceller;

  localparam int WIDTH    = 12;
  localparam int WIN_LOG2 = 8;

  logic                    clk_32M768   = 1'b0;
  logic                    rst_n_32M768 = 1'b0;
  logic signed [WIDTH-1:0] ADC_I        = '0;
  logic signed [WIDTH-1:0] ADC_Q        = '0;
  logic                    in_valid     = 1'b0;
  logic                    freeze       = 1'b0;
  logic                    clear        = 1'b0;
  logic signed [WIDTH-1:0] I_out;
  logic signed [WIDTH-1:0] Q_out;
  logic                    out_valid;
  logic signed [WIDTH-1:0] offset_I;
  logic signed [WIDTH-1:0] offset_Q;
  logic                    locked;

  int vectors     = 0;
  int miscompares = 0;

  rx_dc_offset_canceller #(
    .WIDTH    (WIDTH),
    .WIN_LOG2 (WIN_LOG2)
  ) dut (
    .clk_32M768   (clk_32M768),
    .rst_n_32M768 (rst_n_32M768),
    .ADC_I        (ADC_I),
    .ADC_Q        (ADC_Q),
    .in_valid     (in_valid),
    .freeze       (freeze),
    .clear        (clear),
    .I_out        (I_out),
    .Q_out        (Q_out),
    .out_valid    (out_valid),
    .offset_I     (offset_I),
    .offset_Q     (offset_Q),
    .locked       (locked)
  );

  // Clock generation: about 32.768 MHz, approximated with a 30 ns period.
  always #15 clk_32M768 = ~clk_32M768;

  // Present one sample.
  //   - Drive it at a falling edge and drop in_valid one clock later.
  //   - Returns at the falling edge after the capturing rising edge.
  task automatic send(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q);
    @(negedge clk_32M768);
    ADC_I    = i;
    ADC_Q    = q;
    in_valid = 1'b1;
    @(negedge clk_32M768);
    in_valid = 1'b0;
  endtask

  // Present the same sample n times.
  task automatic send_n(input logic signed [WIDTH-1:0] i, input logic signed [WIDTH-1:0] q,
                        input int n);
    for (int k = 0; k < n; k++) send(i, q);
  endtask

  // Clear pulse with no sample in flight.
  task automatic do_clear();
    @(negedge clk_32M768);
    clear = 1'b1;
    @(negedge clk_32M768);
    clear = 1'b0;
  endtask

  // Reset behaviour.
  //   - Outputs must stay zero while reset is held, even with random inputs.
  //   - After release, out_valid tracks in_valid one cycle later.
  task automatic test_reset();
    rst_n_32M768 = 1'b0;
    repeat (9) begin
      @(negedge clk_32M768);
      ADC_I    = WIDTH'($urandom);
      ADC_Q    = WIDTH'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      freeze   = 1'($urandom_range(0, 1));
      clear    = 1'($urandom_range(0, 1));
    end
    vectors++; if (I_out !== 12'sd0) begin miscompares++; $display("[TB] FAIL reset_I_out: got %0d want 0", I_out); end
    vectors++; if (Q_out !== 12'sd0) begin miscompares++; $display("[TB] FAIL reset_Q_out: got %0d want 0", Q_out); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    vectors++; if (offset_I !== 12'sd0) begin miscompares++; $display("[TB] FAIL reset_offset_I: got %0d want 0", offset_I); end
    vectors++; if (offset_Q !== 12'sd0) begin miscompares++; $display("[TB] FAIL reset_offset_Q: got %0d want 0", offset_Q); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
    ADC_I = '0; ADC_Q = '0; in_valid = 1'b0; freeze = 1'b0; clear = 1'b0;
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    send(12'sd5, -12'sd3);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_valid: got %0b want 1", out_valid); end
    vectors++; if (I_out !== 12'sd5) begin miscompares++; $display("[TB] FAIL post_reset_I: got %0d want 5", I_out); end
    vectors++; if (Q_out !== -12'sd3) begin miscompares++; $display("[TB] FAIL post_reset_Q: got %0d want -3", Q_out); end
    @(negedge clk_32M768);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_valid: got %0b want 0", out_valid); end
    vectors++; if (I_out !== 12'sd5) begin miscompares++; $display("[TB] FAIL idle_hold_I: got %0d want 5", I_out); end
  endtask

  // Constant DC of -16.
  //   - The first window passes -16 through unchanged.
  //   - Lock happens at the 256th sample.
  //   - From then on the output is 0.
  task automatic test_constant_dc();
    do_clear();
    for (int k = 1; k <= 256; k++) begin
      send(-12'sd16, -12'sd16);
      vectors++;
      if (I_out !== -12'sd16 || Q_out !== -12'sd16) begin
        miscompares++; $display("[TB] FAIL const_out[%0d]: got %0d/%0d want -16/-16", k, I_out, Q_out);
      end
      if (k == 255) begin
        vectors++;
        if (locked !== 1'b0 || offset_I !== 12'sd0) begin
          miscompares++; $display("[TB] FAIL const_early: locked %0b offset %0d want 0/0", locked, offset_I);
        end
      end
    end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL const_locked: got %0b want 1", locked); end
    vectors++; if (offset_I !== -12'sd16) begin miscompares++; $display("[TB] FAIL const_offset_I: got %0d want -16", offset_I); end
    vectors++; if (offset_Q !== -12'sd16) begin miscompares++; $display("[TB] FAIL const_offset_Q: got %0d want -16", offset_Q); end
    for (int k = 0; k < 4; k++) begin
      send(-12'sd16, -12'sd16);
      vectors++;
      if (I_out !== 12'sd0 || Q_out !== 12'sd0) begin
        miscompares++; $display("[TB] FAIL const_corrected[%0d]: got %0d/%0d want 0/0", k, I_out, Q_out);
      end
    end
  endtask

  // Rounding checks.
  //   - A half-LSB mean rounds up: +0.5 gives 1, -0.5 gives 0.
  //   - A full-scale negative window gives -2048.
  task automatic test_rounding();
    do_clear();
    send_n(12'sd1, -12'sd1, 128);
    send_n(12'sd0, 12'sd0, 128);
    vectors++; if (offset_I !== 12'sd1) begin miscompares++; $display("[TB] FAIL round_pos_half: got %0d want 1", offset_I); end
    vectors++; if (offset_Q !== 12'sd0) begin miscompares++; $display("[TB] FAIL round_neg_half: got %0d want 0", offset_Q); end
    send(-12'sd2048, -12'sd2048);
    vectors++; if (I_out !== -12'sd2048) begin miscompares++; $display("[TB] FAIL round_sat_low_I: got %0d want -2048", I_out); end
    vectors++; if (Q_out !== -12'sd2048) begin miscompares++; $display("[TB] FAIL round_min_Q: got %0d want -2048", Q_out); end
    send_n(-12'sd2048, -12'sd2048, 255);
    vectors++; if (offset_I !== -12'sd2048) begin miscompares++; $display("[TB] FAIL round_fullscale_I: got %0d want -2048", offset_I); end
    vectors++; if (offset_Q !== -12'sd2048) begin miscompares++; $display("[TB] FAIL round_fullscale_Q: got %0d want -2048", offset_Q); end
    send(-12'sd2048, -12'sd2048);
    vectors++; if (I_out !== 12'sd0) begin miscompares++; $display("[TB] FAIL round_fullscale_out: got %0d want 0", I_out); end
    send(12'sd2047, 12'sd2047);
    vectors++; if (I_out !== 12'sd2047) begin miscompares++; $display("[TB] FAIL round_sat_high: got %0d want 2047", I_out); end
  endtask

  // Saturation at both rails.
  //   - Offset -16 with input 2047 clamps to 2047.
  //   - Offset +16 with input -2048 clamps to -2048.
  task automatic test_saturation();
    do_clear();
    send_n(-12'sd16, -12'sd16, 256);
    vectors++; if (offset_I !== -12'sd16) begin miscompares++; $display("[TB] FAIL sat_setup_neg: got %0d want -16", offset_I); end
    send(12'sd2047, 12'sd2047);
    vectors++; if (I_out !== 12'sd2047) begin miscompares++; $display("[TB] FAIL sat_pos_I: got %0d want 2047", I_out); end
    vectors++; if (Q_out !== 12'sd2047) begin miscompares++; $display("[TB] FAIL sat_pos_Q: got %0d want 2047", Q_out); end
    do_clear();
    send_n(12'sd16, 12'sd16, 256);
    vectors++; if (offset_I !== 12'sd16) begin miscompares++; $display("[TB] FAIL sat_setup_pos: got %0d want 16", offset_I); end
    send(-12'sd2048, -12'sd2048);
    vectors++; if (I_out !== -12'sd2048) begin miscompares++; $display("[TB] FAIL sat_neg_I: got %0d want -2048", I_out); end
    send(-12'sd2032, 12'sd0);
    vectors++; if (I_out !== -12'sd2048) begin miscompares++; $display("[TB] FAIL sat_edge_I: got %0d want -2048", I_out); end
    vectors++; if (Q_out !== -12'sd16) begin miscompares++; $display("[TB] FAIL sat_edge_Q: got %0d want -16", Q_out); end
  endtask

  // Freeze behaviour.
  //   - Freezing mid-window parks the window while correction continues.
  //   - A freeze on the window-end sample blocks the update.
  task automatic test_freeze();
    do_clear();
    send_n(12'sd40, 12'sd40, 100);
    freeze = 1'b1;
    for (int k = 0; k < 50; k++) begin
      send(12'sd40, 12'sd40);
      vectors++;
      if (I_out !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_out[%0d]: got %0d want 40", k, I_out); end
    end
    vectors++; if (offset_I !== 12'sd0) begin miscompares++; $display("[TB] FAIL freeze_hold_offset: got %0d want 0", offset_I); end
    freeze = 1'b0;
    send_n(12'sd40, 12'sd40, 155);
    vectors++;
    if (locked !== 1'b0 || offset_I !== 12'sd0) begin
      miscompares++; $display("[TB] FAIL freeze_early: locked %0b offset %0d want 0/0", locked, offset_I);
    end
    send(12'sd40, 12'sd40);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL freeze_lock: got %0b want 1", locked); end
    vectors++; if (offset_I !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_update_I: got %0d want 40", offset_I); end
    vectors++; if (offset_Q !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_update_Q: got %0d want 40", offset_Q); end
    send_n(12'sd80, 12'sd80, 255);
    vectors++; if (offset_I !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_midwin: got %0d want 40", offset_I); end
    freeze = 1'b1;
    send(12'sd80, 12'sd80);
    freeze = 1'b0;
    vectors++; if (offset_I !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_winend_hold: got %0d want 40", offset_I); end
    vectors++; if (I_out !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_winend_out: got %0d want 40", I_out); end
    send(12'sd80, 12'sd80);
    vectors++; if (offset_I !== 12'sd80) begin miscompares++; $display("[TB] FAIL freeze_resume_update: got %0d want 80", offset_I); end
    vectors++; if (I_out !== 12'sd40) begin miscompares++; $display("[TB] FAIL freeze_resume_out: got %0d want 40", I_out); end
  endtask

  // Clear in the middle of a tracking window.
  //   - The clear-cycle sample is corrected with the old offset.
  //   - The new estimate appears 256 samples later.
  task automatic test_clear();
    send_n(12'sd80, 12'sd80, 100);
    @(negedge clk_32M768);
    ADC_I = 12'sd100; ADC_Q = 12'sd100; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk_32M768);
    in_valid = 1'b0; clear = 1'b0;
    vectors++; if (I_out !== 12'sd20) begin miscompares++; $display("[TB] FAIL clear_sample_I: got %0d want 20", I_out); end
    vectors++; if (offset_I !== 12'sd0) begin miscompares++; $display("[TB] FAIL clear_offset: got %0d want 0", offset_I); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_locked: got %0b want 0", locked); end
    for (int k = 1; k <= 256; k++) begin
      send(-12'sd24, -12'sd24);
      if (k == 1) begin
        vectors++;
        if (I_out !== -12'sd24) begin miscompares++; $display("[TB] FAIL clear_first_out: got %0d want -24", I_out); end
      end
      if (k == 255) begin
        vectors++;
        if (locked !== 1'b0 || offset_I !== 12'sd0) begin
          miscompares++; $display("[TB] FAIL clear_early: locked %0b offset %0d want 0/0", locked, offset_I);
        end
      end
    end
    vectors++; if (offset_I !== -12'sd24) begin miscompares++; $display("[TB] FAIL clear_new_est: got %0d want -24", offset_I); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_relock: got %0b want 1", locked); end
  endtask

  // Asynchronous reset mid-window.
  //   - Outputs drop to zero immediately.
  //   - Estimation restarts exactly as at power-up.
  task automatic test_async_reset();
    send_n(12'sd7, 12'sd7, 50);
    @(negedge clk_32M768);
    #3 rst_n_32M768 = 1'b0;
    #1;
    vectors++;
    if (I_out !== 12'sd0 || Q_out !== 12'sd0 || out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL areset_outputs: got %0d/%0d/%0b want 0/0/0", I_out, Q_out, out_valid);
    end
    vectors++;
    if (offset_I !== 12'sd0 || offset_Q !== 12'sd0 || locked !== 1'b0) begin
      miscompares++; $display("[TB] FAIL areset_estimate: got %0d/%0d/%0b want 0/0/0", offset_I, offset_Q, locked);
    end
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      send(12'sd9, 12'sd9);
      if (k == 1) begin
        vectors++;
        if (I_out !== 12'sd9) begin miscompares++; $display("[TB] FAIL areset_first_out: got %0d want 9", I_out); end
      end
      if (k == 255) begin
        vectors++;
        if (locked !== 1'b0 || offset_I !== 12'sd0) begin
          miscompares++; $display("[TB] FAIL areset_early: locked %0b offset %0d want 0/0", locked, offset_I);
        end
      end
    end
    vectors++; if (offset_I !== 12'sd9) begin miscompares++; $display("[TB] FAIL areset_new_est_I: got %0d want 9", offset_I); end
    vectors++; if (offset_Q !== 12'sd9) begin miscompares++; $display("[TB] FAIL areset_new_est_Q: got %0d want 9", offset_Q); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_relock: got %0b want 1", locked); end
  endtask

  // Test sequence.
  initial begin
    $display("[TB] starting rx_dc_offset_canceller directed tests");
    test_reset();
    test_constant_dc();
    test_rounding();
    test_saturation();
    test_freeze();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
